// File: rtl/ohs_boost_pi_ctrl.sv
// Closed-loop PI voltage controller for the boost model: one PI update per ce,
// anti-windup integrator, clamped duty scaled to a pwm_generator comparator.
module ohs_boost_pi_ctrl #(
  parameter int unsigned data_width    = 32,
  parameter int unsigned data_decimal  = 22,
  parameter int unsigned counter_width = 32
) (
  input  logic                            aclk,
  input  logic                            reset,
  input  logic                            ce,
  input  logic signed [data_width-1:0]    vC,
  input  logic signed [data_width-1:0]    vref,
  input  logic signed [data_width-1:0]    kp,
  input  logic signed [data_width-1:0]    ki,
  input  logic signed [data_width-1:0]    duty_min,
  input  logic signed [data_width-1:0]    duty_max,
  input  logic        [counter_width-1:0] period,
  output logic        [counter_width-1:0] comparator,
  output logic signed [data_width-1:0]    duty,
  output logic                            valid,
  output logic                            sat,
  output logic                            overrun
);

  localparam int unsigned DW = data_width;
  localparam int unsigned DD = data_decimal;
  localparam int unsigned CW = counter_width;
  localparam int unsigned WW = 2 * DW + 1;

  localparam logic signed [WW-1:0] SMAX = WW'({1'b0, {(DW - 1) {1'b1}}});
  localparam logic signed [WW-1:0] SMIN = ~SMAX;

  typedef enum logic [2:0] {
    S_IDLE, S_ERR, S_PROP, S_INT, S_SUM, S_SCALE
  } state_t;

  state_t state, state_next;

  logic signed [DW-1:0] r_vc, r_vref, r_kp, r_ki, r_min, r_max;
  logic        [CW-1:0] r_period;
  logic signed [DW-1:0] r_e, r_p, integ, r_u;
  logic                 r_sat;

  logic                   accept;
  logic signed [WW-1:0]   e_wide, i_wide, u_wide;
  logic signed [DW-1:0]   e_sat, p_sat;
  logic signed [2*DW-1:0] kp_e, ki_e;
  logic        [DW:0]     i_clamp, u_clamp;
  logic        [DW+CW-1:0] scaled;

  function automatic logic signed [DW-1:0] sat_dw(input logic signed [WW-1:0] x);
    logic signed [WW-1:0] y;
    y = x;
    if (y > SMAX) y = SMAX;
    if (y < SMIN) y = SMIN;
    return DW'(y);
  endfunction

  // Upper clamp first, then lower, so duty_min wins when min > max; MSB flags a clamp.
  function automatic logic [DW:0] clamp(input logic signed [WW-1:0] x,
                                        input logic signed [DW-1:0] lo,
                                        input logic signed [DW-1:0] hi);
    logic signed [WW-1:0] y;
    logic                 c;
    y = x;
    c = 1'b0;
    if (y > WW'(hi)) begin
      y = WW'(hi);
      c = 1'b1;
    end
    if (y < WW'(lo)) begin
      y = WW'(lo);
      c = 1'b1;
    end
    return {c, DW'(y)};
  endfunction

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // A ce on the SCALE edge starts the next step back-to-back.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        accept = ce;
        if (ce) state_next = S_ERR;
      end
      S_ERR:   state_next = S_PROP;
      S_PROP:  state_next = S_INT;
      S_INT:   state_next = S_SUM;
      S_SUM:   state_next = S_SCALE;
      S_SCALE: begin
        accept     = ce;
        state_next = ce ? S_ERR : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    e_wide  = WW'(r_vref) - WW'(r_vc);
    e_sat   = sat_dw(e_wide);
    kp_e    = (2 * DW)'(r_kp) * (2 * DW)'(r_e);
    p_sat   = sat_dw(WW'(kp_e >>> DD));
    ki_e    = (2 * DW)'(r_ki) * (2 * DW)'(r_e);
    i_wide  = WW'(ki_e >>> DD) + WW'(integ);
    i_clamp = clamp(i_wide, r_min, r_max);
    u_wide  = WW'(r_p) + WW'(integ);
    u_clamp = clamp(u_wide, r_min, r_max);
    scaled  = (DW + CW)'($unsigned(r_u)) * (DW + CW)'(r_period);
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      r_vc       <= '0;
      r_vref     <= '0;
      r_kp       <= '0;
      r_ki       <= '0;
      r_min      <= '0;
      r_max      <= '0;
      r_period   <= '0;
      r_e        <= '0;
      r_p        <= '0;
      integ      <= '0;
      r_u        <= '0;
      r_sat      <= 1'b0;
      comparator <= '0;
      duty       <= '0;
      valid      <= 1'b0;
      sat        <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (ce && !accept) overrun <= 1'b1;
      if (accept) begin
        r_vc     <= vC;
        r_vref   <= vref;
        r_kp     <= kp;
        r_ki     <= ki;
        r_min    <= duty_min;
        r_max    <= duty_max;
        r_period <= period;
      end
      case (state)
        S_ERR:  r_e   <= e_sat;
        S_PROP: r_p   <= p_sat;
        S_INT:  integ <= i_clamp[DW-1:0];
        S_SUM: begin
          r_u   <= u_clamp[DW-1:0];
          r_sat <= u_clamp[DW];
        end
        S_SCALE: begin
          comparator <= CW'(scaled >> DD);
          duty       <= r_u;
          sat        <= r_sat;
          valid      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ohs_boost_pi_ctrl.sv
// Scoreboard bench for ohs_boost_pi_ctrl: a longint PI model pushes expected
// results on every accepted ce; a monitor pops and compares on each valid.
module tb_ohs_boost_pi_ctrl;

  localparam int DD = 22;
  localparam longint ONE  = 64'd4194304;
  localparam longint D09  = 64'd3774873;
  localparam longint D005 = 64'd209715;

  typedef struct {
    longint duty;
    longint comp;
    longint sat;
    longint due;
  } exp_t;

  logic               aclk = 1'b0;
  logic               reset;
  logic               ce;
  logic signed [31:0] vC, vref, kp, ki, duty_min, duty_max;
  logic        [31:0] period;
  logic        [31:0] comparator;
  logic signed [31:0] duty;
  logic               valid, sat, overrun;

  exp_t   q[$];
  exp_t   got_x;
  int     n_tests = 0;
  int     n_fail  = 0;
  int     cyc     = 0;
  longint m_integ = 0;
  longint last_comp = 0;
  longint last_duty = 0;
  longint prev_comp;

  ohs_boost_pi_ctrl dut (
    .aclk(aclk), .reset(reset), .ce(ce), .vC(vC), .vref(vref), .kp(kp), .ki(ki),
    .duty_min(duty_min), .duty_max(duty_max), .period(period),
    .comparator(comparator), .duty(duty), .valid(valid), .sat(sat), .overrun(overrun)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic longint sat32(input longint x);
    if (x > 64'sd2147483647) return 64'sd2147483647;
    if (x < -64'sd2147483648) return -64'sd2147483648;
    return x;
  endfunction

  // Reference PI step on the current input values.
  task automatic model_push();
    longint e, p, inew, u, lo, hi;
    exp_t x;
    lo = longint'(duty_min);
    hi = longint'(duty_max);
    e = sat32(longint'(vref) - longint'(vC));
    p = sat32((longint'(kp) * e) >>> DD);
    inew = m_integ + ((longint'(ki) * e) >>> DD);
    if (inew > hi) inew = hi;
    if (inew < lo) inew = lo;
    m_integ = inew;
    u = p + m_integ;
    x.sat = 0;
    if (u > hi) begin u = hi; x.sat = 1; end
    if (u < lo) begin u = lo; x.sat = 1; end
    x.duty = u;
    x.comp = (u * longint'(period)) >>> DD;
    x.due  = cyc + 6;
    q.push_back(x);
  endtask

  task automatic set_in(input longint vr, input longint vc, input longint p_k,
                        input longint i_k, input longint mn, input longint mx,
                        input longint per);
    vref = 32'(vr); vC = 32'(vc); kp = 32'(p_k); ki = 32'(i_k);
    duty_min = 32'(mn); duty_max = 32'(mx); period = 32'(per);
  endtask

  // Called at a negedge; ce is sampled on the following posedge.
  task automatic fire();
    ce = 1'b1;
    model_push();
    @(negedge aclk);
    ce = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge aclk);
      n++;
    end
    check("drain_timeout", longint'(q.size()), 0);
  endtask

  always @(posedge aclk) begin
    #1;
    if (!reset) begin
      if (valid) begin
        if (q.size() == 0) begin
          check("valid_unexpected", 1, 0);
        end else begin
          got_x = q.pop_front();
          check("latency", cyc, got_x.due);
          check("duty", longint'(duty), got_x.duty);
          check("comparator", longint'(comparator), got_x.comp);
          check("sat", longint'(sat), got_x.sat);
        end
        last_comp = longint'(comparator);
        last_duty = longint'(duty);
      end else begin
        check("comp_hold", longint'(comparator), last_comp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    ce = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge aclk);
    check("rst_comp", longint'(comparator), 0);
    check("rst_duty", longint'(duty), 0);
    check("rst_valid", longint'(valid), 0);
    check("rst_sat", longint'(sat), 0);
    check("rst_overrun", longint'(overrun), 0);
    @(negedge aclk);
    reset = 1'b0;
    repeat (2) @(negedge aclk);

    // Proportional only: e = 0.25
    set_in(15 * ONE, 61865984, ONE, 0, 0, D09, 1000);
    fire(); drain();
    check("prop_duty", last_duty, 1048576);
    check("prop_comp", last_comp, 250);

    // Upper clamp
    set_in(30 * ONE, 0, ONE, 0, 0, D09, 1000);
    fire(); drain();
    check("upper_duty", last_duty, D09);
    check("upper_comp", last_comp, 899);

    // Integrator ramp with e = 1.0
    set_in(16 * ONE, 15 * ONE, 0, 41943, 0, D09, 1000);
    repeat (10) begin fire(); drain(); end
    check("ramp_duty", last_duty, 419430);
    check("ramp_comp", last_comp, 99);
    repeat (100) begin fire(); drain(); end
    check("windup_duty", last_duty, D09);
    prev_comp = last_comp;
    vref = 32'(14 * ONE);
    fire(); drain();
    check("ramp_down", longint'(last_comp < prev_comp), 1);

    // Back-to-back: ce on the SCALE edge is accepted
    fire();
    repeat (4) @(negedge aclk);
    fire(); drain();
    repeat (3) @(negedge aclk);
    check("b2b_overrun", longint'(overrun), 0);

    // Overrun: second ce two cycles later is ignored
    fire();
    @(negedge aclk);
    ce = 1'b1;
    @(negedge aclk);
    ce = 1'b0;
    drain();
    check("overrun_set", longint'(overrun), 1);
    repeat (20) @(negedge aclk);
    check("overrun_sticky", longint'(overrun), 1);

    // Async reset while in SUM
    set_in(15 * ONE, 61865984, ONE, 0, 0, D09, 1000);
    fire();
    repeat (3) @(negedge aclk);
    reset = 1'b1;
    q.delete();
    m_integ = 0;
    last_comp = 0;
    last_duty = 0;
    #1;
    check("arst_comp", longint'(comparator), 0);
    check("arst_duty", longint'(duty), 0);
    check("arst_valid", longint'(valid), 0);
    check("arst_overrun", longint'(overrun), 0);
    @(negedge aclk);
    reset = 1'b0;
    @(negedge aclk);

    // Lower clamp with negative error
    set_in(0, 15 * ONE, ONE, 0, D005, D09, 1000);
    fire(); drain();
    check("lower_duty", last_duty, D005);
    check("lower_comp", last_comp, 49);

    // kp = ki = 0: duty is the integrator clamped into the new window
    set_in(5 * ONE, 0, 0, 0, 2 * D005, 4 * D005, 1000);
    fire(); drain();
    check("zero_gain_duty", last_duty, 419430);

    // period = 0
    set_in(5 * ONE, 0, ONE, 0, 0, D09, 0);
    fire(); drain();
    check("period0_comp", last_comp, 0);

    // Random operating points
    for (int k = 0; k < 20; k++) begin
      set_in(longint'($urandom_range(0, 125829120)), longint'($urandom_range(0, 125829120)),
             longint'($urandom_range(0, 8388608)), longint'($urandom_range(0, 419430)),
             longint'($urandom_range(0, 419430)), longint'($urandom_range(2097152, 4194304)),
             longint'($urandom_range(1, 5000)));
      fire(); drain();
    end

    repeat (5) @(negedge aclk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ohs_boost_pi_ctrl.md
Name: ohs_boost_pi_ctrl

Overview:
- Closed-loop voltage controller for the boost model: the consumer of the model's vC output and the producer of the pwm_generator comparator.
- Once per model step (ce), it samples vC and computes a fixed-point PI law with an anti-windup integrator.
- It clamps the resulting duty and scales it to a counter comparator for pwm_generator.
- It closes the loop that benches otherwise drive open-loop with a fixed comparator.

Parameters:
- data_width, 32, width of all signed fixed-point operands.
- data_decimal, 22, fractional bits (1.0 = 2**data_decimal).
- counter_width, 32, width of period/comparator (matches pwm_generator).

Ports:
- aclk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ce  in  1  model-step strobe, one aclk wide.
- vC  in  data_width  measured output voltage, signed Q(dw-dd).dd.
- vref  in  data_width  voltage setpoint, same format.
- kp  in  data_width  proportional gain, same format.
- ki  in  data_width  integral gain with the sample period pre-multiplied (ki = Ki*T).
- duty_min  in  data_width  lower duty clamp; required range 0 <= duty_min <= 1.0.
- duty_max  in  data_width  upper duty clamp; required range 0 <= duty_max <= 1.0.
- period  in  counter_width  PWM period in counts.
- comparator  out  counter_width  registered comparator for pwm_generator.
- duty  out  data_width  registered clamped duty.
- valid  out  1  one-cycle pulse when comparator/duty update.
- sat  out  1  high when the last duty was clamped, updated with valid.
- overrun  out  1  sticky; set if ce arrives while busy; cleared only by reset.

Behaviour:
- Reset (async, any state): state=IDLE; integ, comparator, duty, valid, sat, overrun = 0.
- FSM: IDLE -> ERR -> PROP -> INT -> SUM -> SCALE -> IDLE. One state per aclk.
- IDLE: on ce, latch vC, vref, kp, ki, duty_min, duty_max, period into working registers. Input changes after this edge do not affect the cycle.
- ERR: e = vref - vC, computed at dw+1 bits and saturated to signed dw.
- PROP: p = (kp*e) >>> dd. Full 2*dw signed product, arithmetic shift (floor), saturated to dw.
- INT: i_new = integ + ((ki*e) >>> dd), computed at dw+1 bits. The result is clamped to [duty_min, duty_max] (anti-windup), then stored to integ.
- SUM: u = p + integ at dw+1 bits, then clamped:
  - first u = min(u, duty_max), then u = max(u, duty_min); duty_min wins if min > max.
  - sat_next = 1 if either clamp was applied.
- SCALE: comparator <= (u*period) >> dd, floor, truncated to counter_width (result <= period). duty <= u, sat <= sat_next, valid <= 1 for exactly this cycle.
- Latency: ce sampled at edge N; comparator/duty/valid are updated at edge N+5; valid deasserts at N+6.
- ce in any state other than IDLE is ignored and sets overrun. ce on the same edge the FSM returns to IDLE is accepted.
- Outputs hold their values between updates. comparator does not change while valid is low.
- period=0 gives comparator=0. kp=ki=0 gives duty = clamp(integ, min, max).

Test Plan:
- Reset: assert reset mid-SUM state -> comparator=0, duty=0, valid=0, overrun=0 immediately (async), FSM in IDLE; first ce after release starts a clean computation.
- Proportional: dd=22, kp=4194304, ki=0, vref=15.0, vC=14.75, min=0, max=0.9, period=1000; ce -> valid exactly 5 cycles after ce edge, duty=1048576, comparator=250, sat=0.
- Upper clamp: vref=30.0, vC=0, kp=1.0 -> duty=3774873 (0.9), comparator=899 (floor), sat=1.
- Integrator ramp: kp=0, ki=41943, e=1.0, period=1000, min=0; 10 ce -> integ=419430, comparator=99. Continue 100 ce -> integ holds at duty_max (no windup). Then drop vref so e=-1.0 -> comparator decreases on the very next ce.
- Overrun: pulse ce, then ce again 2 cycles later -> second ce ignored, single valid pulse, overrun=1 and stays 1 until reset.
- Lower clamp/negative: vref=0, vC=15.0, kp=1.0, min=0.05 -> duty=209715, comparator=49, sat=1.
